// File: rtl/heater_ctrl_if.sv
// Signal bundle between the ADC front end / host registers and the heater controller.
interface heater_ctrl_if;
  logic        enable;
  logic [15:0] adc_value;
  logic [15:0] adc_hs_value;
  logic [15:0] adc_setpoint;
  logic [7:0]  duty_max;
  logic        clear_fault;
  logic        heater_on;
  logic [15:0] filt_value;
  logic [1:0]  ctrl_state;
  logic        fault_hs;
  logic        fault_stuck;
  logic        sample_tick;

  // Controller side
  modport slave (
    input  enable, adc_value, adc_hs_value, adc_setpoint, duty_max, clear_fault,
    output heater_on, filt_value, ctrl_state, fault_hs, fault_stuck, sample_tick
  );

  // Supplier / observer side
  modport master (
    output enable, adc_value, adc_hs_value, adc_setpoint, duty_max, clear_fault,
    input  heater_on, filt_value, ctrl_state, fault_hs, fault_stuck, sample_tick
  );
endinterface

// File: rtl/heater_ctrl.sv
// Closed-loop printhead heater controller: filtered bang-bang with hysteresis,
// PWM duty ceiling, and latched heatsink / stuck-ADC faults.
// Thermistor convention: a larger ADC code means colder.
module heater_ctrl #(
  parameter int unsigned SAMPLE_DIV  = 1024,
  parameter int unsigned HYST        = 16,
  parameter logic [15:0] HS_TRIP     = 16'h0400,
  parameter int unsigned STUCK_LIMIT = 64
) (
  input  logic         clk48mhz,
  input  logic         rst,
  heater_ctrl_if.slave bus
);

  localparam int unsigned TW = $clog2(SAMPLE_DIV);
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 18;
  localparam int unsigned CW = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HEAT  = 2'd1;
  localparam logic [1:0] ST_COAST = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [TW-1:0] TMR_LAST  = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] STUCK_MAX = CW'(STUCK_LIMIT);
  localparam logic [DW:0]   HYST_X    = (DW+1)'(HYST);
  localparam logic [2:0]    WARM_FULL = 3'd4;

  logic [TW-1:0]       tmr_q;
  logic                sample_tick_q;
  logic                eval_q;
  logic [3:0][DW-1:0]  hist_q;
  logic [2:0]          warm_q;
  logic [CW-1:0]       stuck_q;
  logic                fault_hs_q;
  logic                fault_stuck_q;
  logic [DW-1:0]       filt_q;
  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [7:0]          pwm_q;
  logic                heater_q;

  logic                tick_c;
  logic                hs_det_c;
  logic [CW-1:0]       stuck_inc_c;
  logic [CW-1:0]       stuck_nxt_c;
  logic                stuck_det_c;
  logic [SW-1:0]       sum_c;
  logic [DW:0]         hi_sum_c;
  logic [DW-1:0]       hi_c;
  logic                warm_done_c;
  logic                fault_any_c;
  logic                clr_ok_c;

  // Sample-instant decode and per-sample fault detection
  always_comb begin
    tick_c      = (tmr_q == TMR_LAST);
    hs_det_c    = tick_c && (bus.adc_hs_value < HS_TRIP);
    stuck_inc_c = (stuck_q == STUCK_MAX) ? stuck_q : stuck_q + CW'(1);
    stuck_nxt_c = (bus.adc_value == hist_q[0]) ? stuck_inc_c : '0;
    stuck_det_c = tick_c && (stuck_nxt_c == STUCK_MAX);
  end

  // Moving-average sum and saturating upper hysteresis threshold
  always_comb begin
    sum_c    = SW'(hist_q[0]) + SW'(hist_q[1]) + SW'(hist_q[2]) + SW'(hist_q[3]);
    hi_sum_c = {1'b0, bus.adc_setpoint} + HYST_X;
    hi_c     = hi_sum_c[DW] ? 16'hFFFF : hi_sum_c[DW-1:0];
  end

  // Fault clear is refused when a fault is detected on the same edge
  always_comb begin
    warm_done_c = (warm_q == WARM_FULL);
    fault_any_c = fault_hs_q || fault_stuck_q;
    clr_ok_c    = bus.clear_fault && (state_q == ST_FAULT) && !hs_det_c && !stuck_det_c;
  end

  // Free-running sample timer; strobe and FSM-evaluate pulse are delayed copies of the tick
  always_ff @(posedge clk48mhz) begin
    if (rst) begin
      tmr_q         <= '0;
      sample_tick_q <= 1'b0;
      eval_q        <= 1'b0;
    end else begin
      tmr_q         <= tmr_q + TW'(1);
      sample_tick_q <= tick_c;
      eval_q        <= sample_tick_q;
    end
  end

  // Sample history, stuck counter, warm-up counter and latched fault flags
  always_ff @(posedge clk48mhz) begin
    if (rst) begin
      hist_q        <= '0;
      stuck_q       <= '0;
      warm_q        <= '0;
      fault_hs_q    <= 1'b0;
      fault_stuck_q <= 1'b0;
    end else begin
      if (tick_c) begin
        hist_q  <= {hist_q[2:0], bus.adc_value};
        stuck_q <= stuck_nxt_c;
      end
      if (clr_ok_c) begin
        warm_q <= '0;
      end else if (tick_c && !warm_done_c) begin
        warm_q <= warm_q + 3'd1;
      end
      if (hs_det_c) begin
        fault_hs_q <= 1'b1;
      end else if (clr_ok_c) begin
        fault_hs_q <= 1'b0;
      end
      if (stuck_det_c) begin
        fault_stuck_q <= 1'b1;
      end else if (clr_ok_c) begin
        fault_stuck_q <= 1'b0;
      end
    end
  end

  // Filtered value registered one cycle after the sample
  always_ff @(posedge clk48mhz) begin
    if (rst) begin
      filt_q <= '0;
    end else if (sample_tick_q) begin
      filt_q <= sum_c[SW-1:2];
    end
  end

  // Next-state logic: faults first, enable drop every cycle, thresholds once per sample
  always_comb begin
    state_d = state_q;
    if (state_q == ST_FAULT) begin
      if (clr_ok_c) begin
        state_d = ST_IDLE;
      end
    end else if (fault_any_c) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (eval_q && bus.enable && warm_done_c) begin
            state_d = (filt_q > hi_c) ? ST_HEAT : ST_COAST;
          end
        end
        ST_HEAT: begin
          if (!bus.enable) begin
            state_d = ST_IDLE;
          end else if (eval_q && (filt_q <= bus.adc_setpoint)) begin
            state_d = ST_COAST;
          end
        end
        ST_COAST: begin
          if (!bus.enable) begin
            state_d = ST_IDLE;
          end else if (eval_q && (filt_q > hi_c)) begin
            state_d = ST_HEAT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk48mhz) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // PWM counter and duty-limited heater drive
  always_ff @(posedge clk48mhz) begin
    if (rst) begin
      pwm_q    <= '0;
      heater_q <= 1'b0;
    end else begin
      pwm_q    <= pwm_q + 8'd1;
      heater_q <= (state_q == ST_HEAT) && (pwm_q < bus.duty_max);
    end
  end

  assign bus.heater_on   = heater_q;
  assign bus.filt_value  = filt_q;
  assign bus.ctrl_state  = state_q;
  assign bus.fault_hs    = fault_hs_q;
  assign bus.fault_stuck = fault_stuck_q;
  assign bus.sample_tick = sample_tick_q;

endmodule

// File: tb/tb_heater_ctrl.sv
// Directed bench for heater_ctrl with a short sample period.
module tb_heater_ctrl;

  localparam int unsigned DIV = 16;

  logic clk48mhz;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc;
  int   ones;

  heater_ctrl_if bus ();

  heater_ctrl #(
    .SAMPLE_DIV (DIV),
    .HYST       (16),
    .HS_TRIP    (16'h0400),
    .STUCK_LIMIT(64)
  ) dut (
    .clk48mhz (clk48mhz),
    .rst      (rst),
    .bus      (bus)
  );

  initial clk48mhz = 1'b0;
  always #5 clk48mhz = ~clk48mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk48mhz);
      #1;
    end
  endtask

  // Returns in the cycle where sample_tick is high
  task automatic wait_tick(output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < 4 * DIV) begin
      @(posedge clk48mhz);
      #1;
      cycles++;
      if (bus.sample_tick) seen = 1'b1;
    end
    if (!seen) chk("tick_timeout", 32'(seen), 32'd1);
  endtask

  task automatic do_sample(input logic [15:0] adc);
    int c;
    bus.adc_value = adc;
    wait_tick(c);
  endtask

  // Counts heater-on cycles over one PWM period, flipping the ADC LSB per sample
  task automatic count_heater(output int n);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk48mhz);
      #1;
      if (bus.heater_on) n++;
      if (bus.sample_tick) bus.adc_value = bus.adc_value ^ 16'h0001;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_heater"}, 32'(bus.heater_on),   32'd0);
    chk({tag, "_filt"},   32'(bus.filt_value),  32'd0);
    chk({tag, "_state"},  32'(bus.ctrl_state),  32'd0);
    chk({tag, "_fhs"},    32'(bus.fault_hs),    32'd0);
    chk({tag, "_fstk"},   32'(bus.fault_stuck), 32'd0);
    chk({tag, "_tick"},   32'(bus.sample_tick), 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.enable       = 1'b1;
    bus.adc_value    = 16'h0800;
    bus.adc_hs_value = 16'h0800;
    bus.adc_setpoint = 16'h0700;
    bus.duty_max     = 8'd128;
    bus.clear_fault  = 1'b0;
    step(3);
    chk_all_zero("reset");

    // Warm-up: first tick latency, filter ramp, HEAT after the 4th sample
    rst = 1'b0;
    wait_tick(cyc);
    chk("first_tick_latency", 32'(cyc), 32'(DIV));
    step(1);
    chk("filt_s1", 32'(bus.filt_value), 32'h0200);
    step(1);
    chk("state_s1", 32'(bus.ctrl_state), 32'd0);
    do_sample(16'h0801);
    step(1);
    chk("filt_s2", 32'(bus.filt_value), 32'h0400);
    step(1);
    chk("state_s2", 32'(bus.ctrl_state), 32'd0);
    do_sample(16'h0800);
    step(2);
    chk("state_s3", 32'(bus.ctrl_state), 32'd0);
    do_sample(16'h0801);
    step(1);
    chk("filt_s4", 32'(bus.filt_value), 32'h0800);
    chk("state_s4_early", 32'(bus.ctrl_state), 32'd0);
    step(1);
    chk("state_s4_heat", 32'(bus.ctrl_state), 32'd1);
    step(1);
    count_heater(ones);
    chk("duty_128", 32'(ones), 32'd128);

    // Hysteresis: COAST at setpoint, hold inside band, HEAT above hi
    do_sample(16'h0700);
    do_sample(16'h0700);
    do_sample(16'h0700);
    step(1);
    chk("filt_ramp3", 32'(bus.filt_value), 32'h0740);
    step(1);
    chk("state_ramp3", 32'(bus.ctrl_state), 32'd1);
    do_sample(16'h0700);
    step(1);
    chk("filt_ramp4", 32'(bus.filt_value), 32'h0700);
    step(1);
    chk("state_coast", 32'(bus.ctrl_state), 32'd2);
    do_sample(16'h0708);
    do_sample(16'h0709);
    do_sample(16'h0708);
    do_sample(16'h0709);
    step(1);
    chk("filt_band", 32'(bus.filt_value), 32'h0708);
    step(1);
    chk("state_band", 32'(bus.ctrl_state), 32'd2);
    do_sample(16'h0711);
    do_sample(16'h0712);
    do_sample(16'h0711);
    step(2);
    chk("state_below_hi", 32'(bus.ctrl_state), 32'd2);
    do_sample(16'h0712);
    step(1);
    chk("filt_above_hi", 32'(bus.filt_value), 32'h0711);
    step(1);
    chk("state_reheat", 32'(bus.ctrl_state), 32'd1);

    // Heatsink fault from HEAT, clear, re-warm
    bus.adc_hs_value = 16'h03FF;
    do_sample(16'h0711);
    bus.adc_hs_value = 16'h0800;
    chk("fault_hs_set", 32'(bus.fault_hs), 32'd1);
    step(1);
    chk("state_fault_hs", 32'(bus.ctrl_state), 32'd3);
    step(1);
    chk("heater_off_fault", 32'(bus.heater_on), 32'd0);
    bus.clear_fault = 1'b1;
    step(1);
    bus.clear_fault = 1'b0;
    chk("state_after_clear", 32'(bus.ctrl_state), 32'd0);
    chk("fault_hs_cleared", 32'(bus.fault_hs), 32'd0);
    do_sample(16'h0800);
    do_sample(16'h0801);
    do_sample(16'h0800);
    step(2);
    chk("rewarm_s3", 32'(bus.ctrl_state), 32'd0);
    do_sample(16'h0801);
    step(2);
    chk("rewarm_s4", 32'(bus.ctrl_state), 32'd1);

    // Stuck ADC: a differing sample restarts the run; 64 equal comparisons trip
    for (int i = 0; i < 40; i++) do_sample(16'h0750);
    do_sample(16'h0751);
    chk("stuck_after_break", 32'(bus.fault_stuck), 32'd0);
    do_sample(16'h0750);
    for (int i = 0; i < 63; i++) do_sample(16'h0750);
    chk("stuck_at_63", 32'(bus.fault_stuck), 32'd0);
    do_sample(16'h0750);
    chk("stuck_at_64", 32'(bus.fault_stuck), 32'd1);
    step(1);
    chk("state_fault_stuck", 32'(bus.ctrl_state), 32'd3);
    step(1);
    chk("heater_off_stuck", 32'(bus.heater_on), 32'd0);

    // clear_fault coinciding with a tick that sees a hot heatsink: fault wins
    bus.adc_value    = 16'h0760;
    bus.adc_hs_value = 16'h0100;
    step(DIV - 3);
    bus.clear_fault = 1'b1;
    step(1);
    bus.clear_fault = 1'b0;
    chk("coincide_tick", 32'(bus.sample_tick), 32'd1);
    chk("coincide_fhs", 32'(bus.fault_hs), 32'd1);
    chk("coincide_fstk", 32'(bus.fault_stuck), 32'd1);
    step(2);
    chk("coincide_state", 32'(bus.ctrl_state), 32'd3);
    bus.adc_hs_value = 16'h0800;
    bus.clear_fault  = 1'b1;
    step(1);
    bus.clear_fault = 1'b0;
    chk("clear2_state", 32'(bus.ctrl_state), 32'd0);
    chk("clear2_fhs", 32'(bus.fault_hs), 32'd0);
    chk("clear2_fstk", 32'(bus.fault_stuck), 32'd0);

    // Saturated threshold: setpoint near full scale never enters HEAT
    bus.adc_setpoint = 16'hFFF8;
    do_sample(16'hFFFF);
    do_sample(16'hFFFE);
    do_sample(16'hFFFF);
    do_sample(16'hFFFE);
    step(1);
    chk("filt_fullscale", 32'(bus.filt_value), 32'h0000FFFE);
    step(1);
    chk("state_sat_hi", 32'(bus.ctrl_state), 32'd2);
    do_sample(16'hFFFF);
    step(2);
    chk("state_sat_hi2", 32'(bus.ctrl_state), 32'd2);

    // duty_max extremes in HEAT
    bus.adc_setpoint = 16'h0700;
    bus.duty_max     = 8'd0;
    do_sample(16'h0800);
    step(1);
    chk("filt_wide_sum", 32'(bus.filt_value), 32'h0000C1FF);
    step(1);
    chk("state_heat_d0", 32'(bus.ctrl_state), 32'd1);
    step(1);
    count_heater(ones);
    chk("duty_0", 32'(ones), 32'd0);
    bus.duty_max = 8'd255;
    step(1);
    count_heater(ones);
    chk("duty_255", 32'(ones), 32'd255);

    // Enable drop mid-HEAT
    bus.enable = 1'b0;
    step(1);
    chk("state_enable_off", 32'(bus.ctrl_state), 32'd0);
    step(1);
    chk("heater_enable_off", 32'(bus.heater_on), 32'd0);
    bus.enable = 1'b1;
    do_sample(16'h0800);
    step(2);
    chk("state_reenable", 32'(bus.ctrl_state), 32'd1);

    // Reset mid-HEAT
    step(3);
    rst = 1'b1;
    step(1);
    chk_all_zero("midrst");
    rst = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/heater_ctrl.md
Name: heater_ctrl

Overview:
- Closed-loop printhead heater controller directly downstream of the ADC SPI front end.
- Consumes the 12-bit thermistor conversion (printhead) and heatsink conversion, both zero-extended to 16 bits, plus the temperature setpoint.
- Filters the printhead reading and drives a PWM-limited bang-bang heater output with hysteresis.
- Latches heatsink over-temperature and stuck-ADC faults that force the heater off.
- Thermistor convention: larger ADC code = colder.

Parameters:
- SAMPLE_DIV, 1024, clk48mhz cycles between sample ticks; must be a power of 2, minimum 16.
- HYST, 16, hysteresis band in ADC codes.
- HS_TRIP, 16'h0400, heatsink fault threshold; adc_hs_value < HS_TRIP means too hot.
- STUCK_LIMIT, 64, consecutive identical printhead samples that raise fault_stuck; range 2..255.

Ports:
- clk48mhz  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  heater loop enable.
- adc_value  in  16  printhead thermistor code.
- adc_hs_value  in  16  heatsink thermistor code.
- adc_setpoint  in  16  target code.
- duty_max  in  8  PWM duty ceiling; on-time is duty_max/256.
- clear_fault  in  1  single-cycle pulse that clears latched faults.
- heater_on  out  1  registered heater drive.
- filt_value  out  16  4-sample moving average.
- ctrl_state  out  2  IDLE=0, HEAT=1, COAST=2, FAULT=3.
- fault_hs  out  1  latched heatsink over-temperature.
- fault_stuck  out  1  latched stuck-ADC fault.
- sample_tick  out  1  one-cycle strobe at each sample.

Behaviour:
- Reset (rst=1 at an edge): all outputs 0, ctrl_state=IDLE. Timer, PWM counter, history, warm-up count and stuck count are cleared. Reset mid-operation takes effect at the next edge and overrides every other input.
- Sample timer: free-running counter mod SAMPLE_DIV. sample_tick=1 for one cycle when the counter equals SAMPLE_DIV-1. First tick occurs SAMPLE_DIV cycles after rst is released.
- Filter: on each tick, adc_value shifts into a 4-deep history. An 18-bit sum is formed; filt_value = sum>>2 (truncated), registered one cycle after the tick. A warm-up counter saturates at 4. Control decisions are suppressed until 4 samples have been taken.
- Stuck detect: on each tick, if adc_value equals the previous sample, increment the stuck count; otherwise clear it. When the count reaches STUCK_LIMIT, set fault_stuck. The count saturates.
- Heatsink check: on each tick, adc_hs_value < HS_TRIP sets fault_hs.
- Thresholds: hi = adc_setpoint + HYST, saturating at 16'hFFFF.
- FSM evaluation: the FSM evaluates once per tick, 2 cycles after sample_tick, using the updated filt_value. Fault flags take priority over all transitions below.
  - Any state, fault_hs or fault_stuck set -> FAULT; the state updates on the cycle after the flag sets.
  - IDLE -> HEAT if enable, warm-up complete and filt_value > hi.
  - IDLE -> COAST if enable, warm-up complete and filt_value <= hi.
  - HEAT -> COAST if filt_value <= adc_setpoint.
  - COAST -> HEAT if filt_value > hi.
  - HEAT or COAST -> IDLE on the cycle after enable falls. This is checked every cycle, not only on ticks.
  - FAULT -> IDLE on the cycle after clear_fault=1. The same cycle clears both flags and the warm-up count.
- Fault priority: if clear_fault coincides with a tick that detects a fault, the fault wins; flags stay set and the state stays FAULT.
- PWM: 8-bit free-running counter. Next heater_on = (ctrl_state==HEAT) && (pwm_cnt < duty_max). duty_max=0 never drives the heater; 255 gives 255/256 on-time. The counter wraps 255->0. heater_on is 0 within one cycle of entering FAULT or IDLE.
- Setpoint and duty_max are sampled live with no internal latching.

Test Plan:
- Reset, then hold adc_value=0x800, setpoint=0x700, enable=1, duty_max=128, hs=0x800, varying the LSB each sample. Expect: no state change for the first 3 ticks; HEAT 2 cycles after tick 4; heater_on high exactly 128 of every 256 cycles.
- From HEAT, ramp adc_value down to 0x700, then hold at 0x708, then 0x711. Expect: COAST when filt_value reaches 0x700; stays COAST at 0x708 (inside band); HEAT when filt_value reaches 0x711.
- adc_hs_value=0x03FF for one tick while in HEAT. Expect: fault_hs=1, FAULT, heater_on=0. Pulse clear_fault with hs=0x800. Expect: IDLE, then re-warm over 4 ticks before HEAT.
- adc_value held at a constant 0x750 for 64 ticks. Expect: fault_stuck set on the 64th equal comparison; one differing sample before that resets the count.
- clear_fault on the same cycle that a tick detects hs=0x0100. Expect: fault_hs stays 1, ctrl_state stays FAULT.
- Edge cases: setpoint=0xFFF8 with HYST=16, hi saturates at 0xFFFF, so HEAT is never entered. duty_max=0 gives heater_on=0 in HEAT. Deassert enable mid-HEAT gives IDLE and heater_on=0 within 2 cycles. Assert rst mid-HEAT gives all outputs 0 the next cycle.
